vga_timing_gen: RTL

- Parametrised VGA timing generator that replaces the fixed-640x480 sync block for multi-resolution video paths.
- All timing values are module parameters. Sync polarity is selectable per axis.
- Provides a run/enable control and frame/line strobes.
- Address outputs lead the sync/display outputs by a programmable pipeline delay, so frame-buffer read latency is absorbed without external delay logic.

---
 rtl/vga_timing_gen.sv | 132 +++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with run control, frame/line strobes and address outputs
// that lead the registered sync/display outputs by PIPE_DELAY clocks.
module vga_timing_gen #(
    parameter int unsigned H_DISPLAY  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_DISPLAY  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter bit          HSYNC_POL  = 1'b0,
    parameter bit          VSYNC_POL  = 1'b0,
    parameter int unsigned PIPE_DELAY = 2,
    localparam int unsigned H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK,
    localparam int unsigned V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK,
    localparam int unsigned H_SIZE    = $clog2(H_TOTAL),
    localparam int unsigned V_SIZE    = $clog2(V_TOTAL),
    localparam int unsigned P_SIZE    = $clog2(H_DISPLAY * V_DISPLAY)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic [H_SIZE-1:0] x_addr,
    output logic [V_SIZE-1:0] y_addr,
    output logic              addr_valid,
    output logic [P_SIZE-1:0] pixel_addr,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              display_on,
    output logic              line_start,
    output logic              frame_start
);

    if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_bad_pipe_delay
        $error("vga_timing_gen: PIPE_DELAY must be in 1..4");
    end
    if (H_DISPLAY == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
        V_DISPLAY == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_timing
        $error("vga_timing_gen: timing parameters must be non-zero");
    end

    localparam logic [H_SIZE-1:0] H_LAST     = H_SIZE'(H_TOTAL - 1);
    localparam logic [H_SIZE-1:0] H_DISP_END = H_SIZE'(H_DISPLAY);
    localparam logic [H_SIZE-1:0] H_SYNC_BEG = H_SIZE'(H_DISPLAY + H_FRONT);
    localparam logic [H_SIZE-1:0] H_SYNC_END = H_SIZE'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [V_SIZE-1:0] V_LAST     = V_SIZE'(V_TOTAL - 1);
    localparam logic [V_SIZE-1:0] V_DISP_END = V_SIZE'(V_DISPLAY);
    localparam logic [V_SIZE-1:0] V_SYNC_BEG = V_SIZE'(V_DISPLAY + V_FRONT);
    localparam logic [V_SIZE-1:0] V_SYNC_END = V_SIZE'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [P_SIZE-1:0] P_LAST     = P_SIZE'(H_DISPLAY * V_DISPLAY - 1);

    // Stage layout: {hsync level, vsync level, display, line_start, frame_start}
    localparam logic [4:0] PIPE_IDLE = {~HSYNC_POL, ~VSYNC_POL, 3'b000};

    logic              r_run;
    logic [H_SIZE-1:0] r_h;
    logic [V_SIZE-1:0] r_v;
    logic [P_SIZE-1:0] r_pix;
    logic [4:0]        r_pipe [PIPE_DELAY];

    logic       w_h_wrap;
    logic       w_v_wrap;
    logic       w_valid;
    logic       w_hs_act;
    logic       w_vs_act;
    logic       w_line;
    logic       w_frame;
    logic [4:0] w_stage_in;

    always_comb begin
        w_h_wrap   = (r_h == H_LAST);
        w_v_wrap   = (r_v == V_LAST);
        w_valid    = r_run && (r_h < H_DISP_END) && (r_v < V_DISP_END);
        w_hs_act   = r_run && (r_h >= H_SYNC_BEG) && (r_h < H_SYNC_END);
        w_vs_act   = r_run && (r_v >= V_SYNC_BEG) && (r_v < V_SYNC_END);
        w_line     = r_run && (r_h == '0) && (r_v < V_DISP_END);
        w_frame    = r_run && (r_h == '0) && (r_v == '0);
        w_stage_in = {w_hs_act ? HSYNC_POL : ~HSYNC_POL,
                      w_vs_act ? VSYNC_POL : ~VSYNC_POL,
                      w_valid, w_line, w_frame};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
            r_h   <= '0;
            r_v   <= '0;
            r_pix <= '0;
        end else begin
            r_run <= enable;
            if (!enable) begin
                r_h   <= '0;
                r_v   <= '0;
                r_pix <= '0;
            end else if (r_run) begin
                r_h <= w_h_wrap ? '0 : r_h + 1'b1;
                if (w_h_wrap) begin
                    r_v <= w_v_wrap ? '0 : r_v + 1'b1;
                end
                // Linear index tracks y*H_DISPLAY+x by counting only visible cycles
                if (w_valid) begin
                    r_pix <= (r_pix == P_LAST) ? '0 : r_pix + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_DELAY; i++) begin
                r_pipe[i] <= PIPE_IDLE;
            end
        end else begin
            r_pipe[0] <= w_stage_in;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign x_addr      = r_h;
    assign y_addr      = r_v;
    assign addr_valid  = w_valid;
    assign pixel_addr  = r_pix;
    assign vga_hsync   = r_pipe[PIPE_DELAY-1][4];
    assign vga_vsync   = r_pipe[PIPE_DELAY-1][3];
    assign display_on  = r_pipe[PIPE_DELAY-1][2];
    assign line_start  = r_pipe[PIPE_DELAY-1][1];
    assign frame_start = r_pipe[PIPE_DELAY-1][0];

endmodule
